// File: rtl/hgcal_input_packer.sv
// Input packer for the HGCAL autoencoder: quantizes streamed cell samples and packs one
// full frame into the flat layer-0 vector, holding it under a valid/ready handshake.
//   state  | meaning
//   FILL   | collecting samples into slot `count`
//   RESYNC | frame overran; dropping samples until s_last
//   FULL   | packed frame presented on m_data, waiting for m_ready
module hgcal_input_packer #(
    parameter int NUM_FEATURES = 48,
    parameter int SAMPLE_W     = 10,
    parameter int IN_BITS      = 2,
    parameter int SHIFT        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [SAMPLE_W-1:0]             s_data,
    input  logic                            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
    output logic                            frame_err,
    output logic [7:0]                      err_cnt
);
    localparam int CNT_W = $clog2(NUM_FEATURES);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_FEATURES - 1);
    localparam logic [IN_BITS-1:0] Q_MAX    = '1;

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] RESYNC = 2'd1;
    localparam logic [1:0] FULL   = 2'd2;

    logic [1:0]                 state, state_nx;
    logic [CNT_W-1:0]           count, count_nx, wr_idx;
    logic                       accept, wr_en, err_now;
    logic signed [SAMPLE_W-1:0] shifted;
    logic [IN_BITS-1:0]         q;

    assign s_ready = (state == FULL) ? m_ready : 1'b1;
    assign m_valid = (state == FULL);
    assign accept  = s_valid & s_ready;
    assign shifted = $signed(s_data) >>> SHIFT;

    always_comb begin
        q = '0;
        if (!s_data[SAMPLE_W-1]) begin
            if (shifted > $signed({{(SAMPLE_W-IN_BITS){1'b0}}, Q_MAX}))
                q = Q_MAX;
            else
                q = shifted[IN_BITS-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        wr_en    = 1'b0;
        wr_idx   = count;
        err_now  = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (count == LAST_IDX) begin
                        count_nx = '0;
                        if (s_last) begin
                            state_nx = FULL;
                        end else begin
                            err_now  = 1'b1;
                            state_nx = RESYNC;
                        end
                    end else if (s_last) begin
                        err_now  = 1'b1;
                        count_nx = '0;
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end
            end
            RESYNC: begin
                if (accept && s_last) begin
                    state_nx = FILL;
                    count_nx = '0;
                end
            end
            FULL: begin
                // A sample accepted on the draining cycle starts the next frame at slot 0.
                if (m_ready) begin
                    state_nx = FILL;
                    count_nx = '0;
                    if (accept) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        if (s_last)
                            err_now = 1'b1;
                        else
                            count_nx = CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = FILL;
                count_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            count     <= '0;
            m_data    <= '0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            frame_err <= err_now;
            if (err_now && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            if (wr_en) begin
                for (int i = 0; i < NUM_FEATURES; i++)
                    if (wr_idx == CNT_W'(i))
                        m_data[i*IN_BITS +: IN_BITS] <= q;
            end
        end
    end
endmodule
